// File: rtl/resp_multicast_buffer_icache_intc_pkg.sv
// icache_intc_resp_pkg: shared sizing helpers and assertion predicates for the response path
package icache_intc_resp_pkg;
  function automatic int clog2_depth(input int d);
    int r = 0;
    while ((1 << r) < d) r++;
    return (r == 0) ? 1 : r;
  endfunction
  function automatic int cnt_width(input int depth);
    return clog2_depth(depth + 1);
  endfunction
  function automatic logic onehot_or_zero(input logic [63:0] v);
    return (v & (v - 64'd1)) == 64'd0;
  endfunction
endpackage

// File: rtl/resp_multicast_buffer_icache_intc_fifo.sv
// resp_fifo_icache_intc: generic synchronous FIFO with wrap-around pointers and separate occupancy count
module resp_fifo_icache_intc
  import icache_intc_resp_pkg::*;
#(
  parameter int WIDTH = 144,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic                        full,
  output logic                        empty,
  output logic [cnt_width(DEPTH)-1:0] count
);
  localparam int AW = clog2_depth(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic push_ok, pop_ok;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign push_ok = push && !full;
  assign pop_ok = pop && !empty;
  assign rdata = mem[rd];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        mem[wr] <= wdata;
        wr <= wr + 1'b1;
      end
      if (pop_ok) rd <= rd + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/resp_multicast_buffer_icache_intc.sv
// resp_multicast_buffer_icache_intc: buffers bank refill responses and multicasts each to all cores in its UID mask
module resp_multicast_buffer_icache_intc
  import icache_intc_resp_pkg::*;
#(
  parameter int N_CORES    = 16,
  parameter int DATA_WIDTH = 128,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             response_valid_i,
  input  logic [DATA_WIDTH-1:0]            response_rdata_i,
  input  logic [N_CORES-1:0]               response_UID_i,
  output logic                             response_ready_o,
  output logic [N_CORES-1:0]               response_valid_o,
  output logic [DATA_WIDTH-1:0]            response_rdata_o,
  input  logic [N_CORES-1:0]               response_ready_i,
  output logic                             uid_error_o,
  output logic [cnt_width(FIFO_DEPTH)-1:0] count_o
);
  logic [N_CORES+DATA_WIDTH-1:0] head;
  logic [N_CORES-1:0] head_uid, served, take, done;
  logic [DATA_WIDTH-1:0] head_data;
  logic [cnt_width(FIFO_DEPTH)-1:0] cnt;
  logic full, empty, push, drop, pop;
  assign {head_uid, head_data} = head;
  assign response_ready_o = !full && !rst_i;
  assign push = response_valid_i && response_ready_o && |response_UID_i;
  assign drop = response_valid_i && response_ready_o && ~|response_UID_i;
  assign response_valid_o = (empty || rst_i) ? '0 : head_uid & ~served;
  assign response_rdata_o = head_data;
  assign count_o = rst_i ? '0 : cnt;
  // the head retires once no target remains that has neither been served nor is taking it now
  assign take = response_valid_o & response_ready_i;
  assign done = head_uid & ~(served | take);
  assign pop = !empty && !rst_i && done == '0;
  resp_fifo_icache_intc #(.WIDTH(N_CORES + DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_i),
    .rst(rst_i),
    .push(push),
    .pop(pop),
    .wdata({response_UID_i, response_rdata_i}),
    .rdata(head),
    .full(full),
    .empty(empty),
    .count(cnt)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      served <= '0;
      uid_error_o <= 1'b0;
    end else begin
      served <= pop ? '0 : served | take;
      uid_error_o <= drop;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (onehot_or_zero(64'({push, drop})));
  end
endmodule

// File: tb/tb_resp_multicast_buffer_icache_intc.sv
// tb_resp_multicast_buffer_icache_intc: directed stimulus, per-cycle queue model comparison plus literal spot checks
module tb_resp_multicast_buffer_icache_intc;
  logic clk = 0;
  logic rst_i = 1;
  logic response_valid_i = 0;
  logic [127:0] response_rdata_i = '0;
  logic [15:0] response_UID_i = '0;
  logic response_ready_o;
  logic [15:0] response_valid_o;
  logic [127:0] response_rdata_o;
  logic [15:0] response_ready_i = '0;
  logic uid_error_o;
  logic [2:0] count_o;
  int pass_cnt = 0;
  int total = 0;
  bit en = 0;

  resp_multicast_buffer_icache_intc dut (
    .clk_i(clk), .rst_i(rst_i), .response_valid_i(response_valid_i),
    .response_rdata_i(response_rdata_i), .response_UID_i(response_UID_i),
    .response_ready_o(response_ready_o), .response_valid_o(response_valid_o),
    .response_rdata_o(response_rdata_o), .response_ready_i(response_ready_i),
    .uid_error_o(uid_error_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] rem;
    logic [127:0] data;
  } ent_t;
  ent_t q[$];
  logic exp_err = 0;

  function automatic void chk(string n, logic [127:0] a, logic [127:0] e);
    total++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s act=%h exp=%h t=%0t", n, a, e, $time);
  endfunction

  // each queued response keeps the set of cores still owed a copy
  always @(posedge clk) begin
    if (rst_i) begin
      q.delete();
      exp_err = 0;
    end else begin
      logic ok;
      ok = q.size() < 4;
      exp_err = response_valid_i && ok && response_UID_i == 0;
      if (q.size() > 0) begin
        ent_t h;
        h = q[0];
        h.rem = h.rem & ~response_ready_i;
        if (h.rem == 0) void'(q.pop_front());
        else q[0] = h;
      end
      if (response_valid_i && ok && response_UID_i != 0)
        q.push_back('{rem: response_UID_i, data: response_rdata_i});
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("ready", 128'(response_ready_o), rst_i ? 128'd0 : 128'(q.size() < 4));
      chk("valid", 128'(response_valid_o), (rst_i || q.size() == 0) ? 128'd0 : 128'(q[0].rem));
      if (!rst_i && q.size() > 0) chk("rdata", response_rdata_o, q[0].data);
      chk("count", 128'(count_o), rst_i ? 128'd0 : 128'(q.size()));
      chk("uid_err", 128'(uid_error_o), 128'(exp_err));
    end
  end

  task automatic step(input logic v, input logic [15:0] uid, input logic [127:0] d, input logic [15:0] rdy);
    response_valid_i = v;
    response_UID_i = uid;
    response_rdata_i = d;
    response_ready_i = rdy;
    @(posedge clk);
    #2;
  endtask

  localparam logic [127:0] A = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] B = 128'hBBBB_CCCC_DDDD_EEEE_FFFF_0123_4567_89AB;

  function automatic logic [127:0] dk(input int k);
    return 128'hD000 + 128'(k);
  endfunction

  initial begin
    step(0, 0, 0, 0);
    en = 1;
    step(0, 0, 0, 0);
    chk("rst_ready_low", 128'(response_ready_o), 128'd0);
    rst_i = 0;
    step(1, 16'h0001, A, 0);
    step(1, 16'h0001, B, 0);
    chk("pre_rst_count", 128'(count_o), 128'd2);
    rst_i = 1;
    step(0, 0, 0, 0);
    chk("rst_count", 128'(count_o), 128'd0);
    chk("rst_valid", 128'(response_valid_o), 128'd0);
    rst_i = 0;
    #1;
    chk("post_rst_ready", 128'(response_ready_o), 128'd1);
    step(0, 0, 0, '1);
    chk("post_rst_valid", 128'(response_valid_o), 128'd0);

    step(1, 16'h0004, A, '1);
    chk("uc_valid", 128'(response_valid_o), 128'h0004);
    chk("uc_rdata", response_rdata_o, A);
    step(0, 0, 0, '1);
    chk("uc_count", 128'(count_o), 128'd0);
    chk("uc_valid_gone", 128'(response_valid_o), 128'd0);

    step(1, 16'h0011, B, 16'h0000);
    chk("mc_valid1", 128'(response_valid_o), 128'h0011);
    step(0, 0, 0, 16'h0001);
    chk("mc_valid2", 128'(response_valid_o), 128'h0010);
    chk("mc_rdata_stable", response_rdata_o, B);
    step(0, 0, 0, 16'h0000);
    chk("mc_valid3", 128'(response_valid_o), 128'h0010);
    step(0, 0, 0, 16'h0011);
    chk("mc_popped_valid", 128'(response_valid_o), 128'd0);
    chk("mc_popped_count", 128'(count_o), 128'd0);

    for (int k = 0; k < 4; k++) step(1, 16'h0002, dk(k), 0);
    chk("full_count", 128'(count_o), 128'd4);
    chk("full_ready", 128'(response_ready_o), 128'd0);
    step(1, 16'h0002, dk(4), 0);
    chk("full_held", 128'(count_o), 128'd4);
    chk("full_head", response_rdata_o, dk(0));
    step(1, 16'h0002, dk(4), 16'h0002);
    chk("pop_nopush_count", 128'(count_o), 128'd3);
    chk("pop_nopush_ready", 128'(response_ready_o), 128'd1);
    chk("order1", response_rdata_o, dk(1));
    step(1, 16'h0002, dk(4), 16'h0002);
    chk("push_pop_count", 128'(count_o), 128'd3);
    for (int k = 2; k < 5; k++) begin
      chk("order", response_rdata_o, dk(k));
      step(0, 0, 0, 16'h0002);
    end
    chk("drain_count", 128'(count_o), 128'd0);

    #1;
    chk("uid0_ready", 128'(response_ready_o), 128'd1);
    step(1, 16'h0000, A, '1);
    chk("uid0_err", 128'(uid_error_o), 128'd1);
    chk("uid0_count", 128'(count_o), 128'd0);
    step(0, 0, 0, '1);
    chk("uid0_err_pulse", 128'(uid_error_o), 128'd0);

    step(1, 16'h8001, A, 16'h8000);
    step(1, 16'hFFFF, B, 16'h0001);
    step(0, 0, 0, 16'h7FFF);
    step(0, 0, 0, '1);
    step(0, 0, 0, '1);
    chk("final_count", 128'(count_o), 128'd0);
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
